// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader state encoding and RAM direction codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_COUNT,
    LD_DATA,
    LD_WRITE,
    LD_CHECK,
    LD_DONE,
    LD_ERR
  } ld_state_e;

  localparam logic RAM_RD = 1'b1;
  localparam logic RAM_WR = 1'b0;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into big-endian 32-bit words (first byte ends up in 31:24).
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Shift the new byte in from the bottom; clear has priority over shift.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  // Packer state register; counter wraps to 0 after the fourth byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  // High in the cycle whose shift completes a word, so the write can follow at once.
  assign word_full_o = shift_i && !clr_i && (cnt_q == 2'd3);
  assign word_o      = word_q;

endmodule

// File: rtl/instr_loader.sv
// Boot-time loader: byte stream -> 32-bit words -> instruction RAM, XOR-checked.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [7:0]        Byte_in,
  input  logic              Byte_valid,
  output logic              Byte_ready,
  output logic              Enable_i,
  output logic              RW_ram_i,
  output logic [ADDR_W-1:0] Address_in_i,
  output logic [31:0]       In_i,
  output logic              Bus_own,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic              Cpu_run
);

  ld_state_e   state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic        xfer;
  logic        pk_shift;
  logic        pk_clr;
  logic        pk_full;
  logic [31:0] pk_word;

  assign xfer     = Byte_valid && Byte_ready;
  assign pk_shift = xfer && (state_q == LD_DATA);
  assign pk_clr   = (state_q == LD_COUNT) || (state_q == LD_WRITE);

  byte_packer u_packer (
    .clk_i       (Clk),
    .rst_ni      (Reset_n),
    .clr_i       (pk_clr),
    .shift_i     (pk_shift),
    .byte_i      (Byte_in),
    .word_o      (pk_word),
    .word_full_o (pk_full)
  );

  // Next-state logic for the load sequence, word index and running checksum.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (Start) state_d = LD_COUNT;
      end
      LD_COUNT: begin
        if (xfer) begin
          n_d     = Byte_in;
          csum_d  = Byte_in;
          idx_d   = '0;
          state_d = (Byte_in == 8'd0) ? LD_CHECK : LD_DATA;
        end
      end
      LD_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ Byte_in;
          if (pk_full) state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = ((idx_q + 8'd1) == n_q) ? LD_CHECK : LD_DATA;
      end
      LD_CHECK: begin
        if (xfer) state_d = (Byte_in == csum_q) ? LD_DONE : LD_ERR;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // State and bookkeeping registers; reset aborts any load in progress.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= LD_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
    end
  end

  // Port drive decoded from state: the RAM sees a write only during WRITE.
  always_comb begin
    Byte_ready   = 1'b0;
    Enable_i     = 1'b0;
    RW_ram_i     = RAM_RD;
    Address_in_i = '0;
    In_i         = '0;
    if (state_q == LD_COUNT || state_q == LD_DATA || state_q == LD_CHECK) begin
      Byte_ready = 1'b1;
    end
    if (state_q == LD_WRITE) begin
      Enable_i     = 1'b1;
      RW_ram_i     = RAM_WR;
      Address_in_i = BASE_ADDR + ADDR_W'(idx_q);
      In_i         = pk_word;
    end
  end

  assign Busy    = (state_q == LD_COUNT) || (state_q == LD_DATA) ||
                   (state_q == LD_WRITE) || (state_q == LD_CHECK);
  assign Bus_own = Busy;
  assign Done    = (state_q == LD_DONE);
  assign Error   = (state_q == LD_ERR);
  assign Cpu_run = Done;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader against a stream-level reference model.
module tb_instr_loader;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [7:0]  Byte_in;
  logic        Byte_valid;

  logic        Byte_ready, Enable_i, RW_ram_i, Bus_own, Busy, Done, Error, Cpu_run;
  logic [15:0] Address_in_i;
  logic [31:0] In_i;

  logic        w_Byte_ready, w_Enable_i, w_RW_ram_i, w_Bus_own, w_Busy, w_Done, w_Error, w_Cpu_run;
  logic [15:0] w_Address_in_i;
  logic [31:0] w_In_i;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram0 [int];
  logic [47:0] wlog0[$];
  logic [47:0] wlog1[$];

  instr_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Byte_in(Byte_in), .Byte_valid(Byte_valid),
    .Byte_ready(Byte_ready), .Enable_i(Enable_i), .RW_ram_i(RW_ram_i),
    .Address_in_i(Address_in_i), .In_i(In_i), .Bus_own(Bus_own), .Busy(Busy),
    .Done(Done), .Error(Error), .Cpu_run(Cpu_run)
  );

  instr_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFF)) u_wrap (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Byte_in(Byte_in), .Byte_valid(Byte_valid),
    .Byte_ready(w_Byte_ready), .Enable_i(w_Enable_i), .RW_ram_i(w_RW_ram_i),
    .Address_in_i(w_Address_in_i), .In_i(w_In_i), .Bus_own(w_Bus_own), .Busy(w_Busy),
    .Done(w_Done), .Error(w_Error), .Cpu_run(w_Cpu_run)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM write monitors, sampled mid-cycle
  always @(negedge Clk) begin
    if (Enable_i === 1'b1 && RW_ram_i === 1'b0) begin
      ram0[int'(Address_in_i)] = In_i;
      wlog0.push_back({Address_in_i, In_i});
      chk("rdy_in_write", Byte_ready, 1'b0);
    end
    if (w_Enable_i === 1'b1 && w_RW_ram_i === 1'b0) begin
      wlog1.push_back({w_Address_in_i, w_In_i});
    end
  end

  // Reference: words and checksum verdict straight from the stream format
  function automatic void ref_model(input logic [7:0] s[$], output logic [31:0] w[$],
                                    output logic good);
    int n;
    logic [7:0] x;
    n = int'(s[0]);
    x = s[0];
    w = {};
    for (int i = 0; i < n; i++) begin
      w.push_back({s[1+4*i], s[2+4*i], s[3+4*i], s[4+4*i]});
      x = x ^ s[1+4*i] ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i];
    end
    good = (x == s[4*n+1]);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int pct);
    int guard = 0;
    bit sent  = 0;
    while (!sent && guard < 500) begin
      @(negedge Clk);
      Byte_in    = b;
      Byte_valid = ($urandom_range(99) < pct);
      if (Byte_valid && Byte_ready) begin
        @(posedge Clk);
        #1;
        sent = 1;
      end
      guard++;
    end
    chk("byte_sent", sent, 1'b1);
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Byte_valid = 1'b0;
    Start      = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] s[$], input int pct, input int restart_at,
                          input string tag);
    logic [31:0] ew[$];
    logic        good;
    logic [15:0] wa;
    ref_model(s, ew, good);
    wlog0.delete();
    wlog1.delete();
    pulse_start();
    chk({tag, "_busy_start"}, Busy, 1'b1);
    chk({tag, "_rdy_start"}, Byte_ready, 1'b1);
    chk({tag, "_done_clr"}, Done, 1'b0);
    chk({tag, "_err_clr"}, Error, 1'b0);
    foreach (s[i]) begin
      if (i == restart_at) begin
        pulse_start();
        chk({tag, "_busy_restart"}, Busy, 1'b1);
      end
      send_byte(s[i], pct);
    end
    Byte_valid = 1'b0;
    chk({tag, "_done"}, Done, good);
    chk({tag, "_error"}, Error, !good);
    chk({tag, "_cpu_run"}, Cpu_run, good);
    chk({tag, "_bus_own"}, Bus_own, 1'b0);
    chk({tag, "_busy_end"}, Busy, 1'b0);
    chk({tag, "_wrap_done"}, w_Done, good);
    chk({tag, "_nwrites"}, wlog0.size(), ew.size());
    chk({tag, "_nwrites_wrap"}, wlog1.size(), ew.size());
    foreach (ew[i]) begin
      if (i < wlog0.size()) begin
        chk({tag, "_addr"}, wlog0[i][47:32], i);
        chk({tag, "_data"}, wlog0[i][31:0], ew[i]);
      end
      if (i < wlog1.size()) begin
        wa = 16'hFFFF + 16'(i);
        chk({tag, "_wrap_addr"}, wlog1[i][47:32], wa);
        chk({tag, "_wrap_data"}, wlog1[i][31:0], ew[i]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"}, Byte_ready, 1'b0);
    chk({tag, "_en"}, Enable_i, 1'b0);
    chk({tag, "_rw"}, RW_ram_i, 1'b1);
    chk({tag, "_addr"}, Address_in_i, 16'h0);
    chk({tag, "_in"}, In_i, 32'h0);
    chk({tag, "_bus_own"}, Bus_own, 1'b0);
    chk({tag, "_busy"}, Busy, 1'b0);
    chk({tag, "_done"}, Done, 1'b0);
    chk({tag, "_error"}, Error, 1'b0);
    chk({tag, "_cpu_run"}, Cpu_run, 1'b0);
  endtask

  initial begin
    logic [7:0] basic[$];
    logic [7:0] badck[$];
    logic [7:0] empty[$];
    logic [7:0] rs[$];
    logic [7:0] x;
    int n;

    basic = {8'h02, 8'hE1, 8'hA0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h40};
    badck = {8'h02, 8'hE1, 8'hA0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h41};
    empty = {8'h00, 8'h00};

    Reset_n    = 1'b0;
    Start      = 1'b0;
    Byte_in    = 8'h00;
    Byte_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    run_load(basic, 100, -1, "basic");
    chk("basic_ram0", ram0[0], 32'hE1A00001);
    chk("basic_ram1", ram0[1], 32'h00000002);
    run_load(badck, 100, -1, "badck");
    run_load(basic, 100, -1, "reload");
    run_load(empty, 100, -1, "empty");
    ram0.delete();
    run_load(basic, 30, -1, "stall");
    chk("stall_ram0", ram0[0], 32'hE1A00001);
    chk("stall_ram1", ram0[1], 32'h00000002);
    run_load(basic, 100, 3, "restart");

    // Abort after count byte plus six data bytes
    ram0.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(basic[i], 100);
    @(negedge Clk);
    Byte_valid = 1'b0;
    Reset_n    = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk("midreset_ram0", ram0[0], 32'hE1A00001);
    @(negedge Clk);
    Reset_n = 1'b1;
    run_load(basic, 100, -1, "after_reset");

    for (int t = 0; t < 5; t++) begin
      rs = {};
      n  = $urandom_range(0, 5);
      rs.push_back(8'(n));
      x = 8'(n);
      for (int j = 0; j < 4 * n; j++) begin
        rs.push_back(8'($urandom_range(255)));
        x = x ^ rs[rs.size()-1];
      end
      if ($urandom_range(3) == 0) x = x ^ 8'(1 << $urandom_range(7));
      rs.push_back(x);
      run_load(rs, $urandom_range(30, 100), -1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction loader for the master CPU. It receives a program as a byte stream from a host link, packs each group of four bytes into a 32-bit instruction word, and writes the words sequentially into the instruction RAM through its write port. A trailing XOR checksum validates the load. The block owns the instruction-RAM port while loading and releases it to the fetch path on completion. It replaces the simulation-only `$readmemh` preload with a synthesizable path.

## Interface
- `ADDR_W`, 16: instruction-RAM address width.
- `BASE_ADDR`, 0: RAM address of the first loaded word.
- `Clk` input 1: sole clock; all state updates on the rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Start` input 1: single-cycle request to begin a load. Honoured only in IDLE, DONE or ERR.
- `Byte_in` input 8: stream data byte.
- `Byte_valid` input 1: `Byte_in` is valid.
- `Byte_ready` output 1: loader accepts a byte this cycle.
- `Enable_i` output 1: instruction-RAM enable.
- `RW_ram_i` output 1: instruction-RAM direction, 1 = read, 0 = write.
- `Address_in_i` output ADDR_W: instruction-RAM address.
- `In_i` output 32: instruction-RAM write data.
- `Bus_own` output 1: loader drives the RAM port; the top level muxes the fetch path off while this is high.
- `Busy` output 1: load in progress.
- `Done` output 1: load completed with a good checksum; held until the next `Start`.
- `Error` output 1: checksum mismatch; held until the next `Start`.
- `Cpu_run` output 1: equal to `Done`; gates the CPU fetch.

## Operation
- **Stream format:** count byte N (number of words, 0–255), then 4·N data bytes, then one checksum byte.
  - Each word is big-endian: the first byte lands in bits 31:24.
  - Checksum = XOR of the count byte and all data bytes.
- **Transfer rule:** a byte transfers on a rising edge with `Byte_valid && Byte_ready`. `Byte_valid` may rise or fall freely; the loader never drops a byte.
- **States:**
  - IDLE: `Start` → COUNT.
  - COUNT: `Byte_ready`=1. On transfer, latch N, init checksum = byte, clear word index; N=0 → CHECK, else → DATA.
  - DATA: `Byte_ready`=1. On each transfer, shift byte into the packer and XOR into the checksum. After the 4th byte → WRITE.
  - WRITE: `Byte_ready`=0. Drive `Enable_i`=1, `RW_ram_i`=0, `Address_in_i`=BASE_ADDR+index, `In_i`=packed word for exactly one cycle. Then index+1. If index+1==N → CHECK, else → DATA.
  - CHECK: `Byte_ready`=1. On transfer, byte == checksum → DONE, else → ERR.
  - DONE: `Done`=`Cpu_run`=1. `Start` → COUNT, clearing `Done`.
  - ERR: `Error`=1, `Cpu_run`=0. `Start` → COUNT, clearing `Error`.
- **`Busy`** = state ∈ {COUNT, DATA, WRITE, CHECK}. `Bus_own` = `Busy`.
- **Outside WRITE:** `Enable_i`=0, `RW_ram_i`=1, `Address_in_i`=0, `In_i`=0.
- **Address arithmetic:** BASE_ADDR+index is computed modulo 2^ADDR_W, so it wraps silently.
- **Restart:** `Start` while `Busy` is ignored.

## Timing
- **Reset values** (also applied asynchronously on `Reset_n` low): state IDLE, and all of the following cleared: `Byte_ready`, `Enable_i`, `Address_in_i`, `In_i`, `Bus_own`, `Busy`, `Done`, `Error`, `Cpu_run`, plus the index, checksum and packer. `RW_ram_i`=1.
- **Start:** `Start` at edge k → `Busy` and `Byte_ready` high after edge k.
- **Throughput:** 5 cycles per word minimum (4 byte cycles + 1 write cycle).
- **Write latency:** the write cycle immediately follows the cycle in which the 4th byte transferred.
- **Completion:** `Done`/`Error` asserts one cycle after the checksum byte transfers.
- **Reset mid-load:** the load aborts and the port is released immediately. Words already written stay in RAM. `Done` stays 0 until a full good load.

## Structure
- Shared package `cpu_pkg`:
  - loader state enum (IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR);
  - `RAM_RD`=1 and `RAM_WR`=0 constants for the RAM direction.
- Sub-module `byte_packer`: 8-bit shift-in, 2-bit byte counter, `word_full` flag, clear input. The FSM, index counter and checksum stay in `instr_loader`.

## Test plan
- **Basic load:** after reset, `Start`; stream 02, E1 A0 00 01, 00 00 00 02, checksum 40 with `Byte_valid` always high.
  - Required: RAM[0]=E1A00001 and RAM[1]=00000002; exactly two `Enable_i`/`RW_ram_i`=0 cycles; `Done`=`Cpu_run`=1 one cycle after the checksum byte; `Bus_own`=0.
- **Checksum error:** same stream with checksum 41.
  - Required: words still written; `Error`=1, `Done`=0, `Cpu_run`=0. A second `Start` with the good stream yields `Done`=1 and `Error`=0.
- **Empty load:** stream 00, checksum 00.
  - Required: no RAM writes; `Done`=1.
- **Stalled source:** `Byte_valid` toggles randomly with a 30% duty cycle.
  - Required: RAM contents match the basic load; no byte lost or duplicated; `Byte_ready`=0 in every WRITE cycle.
- **Reset mid-load:** assert `Reset_n`=0 after 6 data bytes.
  - Required: all outputs at reset values in the same cycle; RAM[0] retains E1A00001; a fresh `Start` reloads correctly.
- **Busy restart and wrap:** `Start` pulsed mid-load is ignored (the load completes normally). With BASE_ADDR=FFFF and N=2, the words land at FFFF then 0000.
